// File: rtl/fp16_mul_arbiter_if.sv
// fp16_mul_arbiter_if: request, response and multiplier-core signals of the
// shared FP16 multiplier arbiter. The arbiter connects through the slave
// modport. The requesters and the multiplier core connect through master.
interface fp16_mul_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic        resp0_valid;
  logic        resp0_ready;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [15:0] resp_p;
  logic        mul_start;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_done;
  logic [15:0] mul_p;
  logic        busy;
  logic        grant_id;
  logic        err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           resp0_ready, resp1_ready, mul_done, mul_p,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_p,
           mul_start, mul_a, mul_b, busy, grant_id, err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
           resp0_ready, resp1_ready, mul_done, mul_p,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_p,
           mul_start, mul_a, mul_b, busy, grant_id, err
  );
endinterface

// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: shares one multi-cycle FP16 multiplier between two
// requesters. Ties are broken round-robin. Operands and the product pass
// through bit-exact.
// Optional: define FP_ARB_WATCHDOG_EN to abort a WAIT after TIMEOUT cycles.
// On an abort the product is a qNaN (16'h7E00) and err is set. err stays set
// until the next reset.
module fp16_mul_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic              clk,
  input  logic              rst,
  fp16_mul_arbiter_if.slave bus
);

  if ((2 ** TW) <= TIMEOUT) begin : g_tw_check
    $error("fp16_mul_arbiter: TW too narrow for TIMEOUT");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        grant_id;
  logic        busy;
  logic        mul_start;
  logic        resp0_valid;
  logic        resp1_valid;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [15:0] resp_p;
  logic        idle;
  logic        pick;
  logic        accept;
  logic        resp_xfer;
  logic        wd_fire;
  logic        err;

  assign idle      = (state == S_IDLE);
  assign pick      = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
  assign accept    = bus.req0_ready || bus.req1_ready;
  assign resp_xfer = grant_id ? bus.resp1_ready : bus.resp0_ready;

  assign bus.req0_ready  = idle && bus.req0_valid && !pick;
  assign bus.req1_ready  = idle && bus.req1_valid && pick;
  assign bus.resp0_valid = resp0_valid;
  assign bus.resp1_valid = resp1_valid;
  assign bus.resp_p      = resp_p;
  assign bus.mul_start   = mul_start;
  assign bus.mul_a       = mul_a;
  assign bus.mul_b       = mul_b;
  assign bus.busy        = busy;
  assign bus.grant_id    = grant_id;
  assign bus.err         = err;

`ifdef FP_ARB_WATCHDOG_EN
  logic [TW-1:0] wd_cnt;

  assign wd_fire = (wd_cnt == TW'(TIMEOUT - 1));

  // Watchdog: count WAIT cycles from zero and latch a sticky error on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == S_WAIT) wd_cnt <= wd_cnt + TW'(1);
      else                 wd_cnt <= '0;
      if (state == S_WAIT && !bus.mul_done && wd_fire) err <= 1'b1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign err     = 1'b0;
`endif

  // Sequencer: arbitrate in IDLE, pulse start, wait for the core, then hold the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      mul_start   <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      mul_a       <= 16'h0000;
      mul_b       <= 16'h0000;
      resp_p      <= 16'h0000;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            mul_a     <= pick ? bus.req1_a : bus.req0_a;
            mul_b     <= pick ? bus.req1_b : bus.req0_b;
            grant_id  <= pick;
            busy      <= 1'b1;
            mul_start <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mul_start <= 1'b0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_done) begin
            resp_p      <= bus.mul_p;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
            state       <= S_RESP;
          end else if (wd_fire) begin
            resp_p      <= 16'h7E00;
            resp0_valid <= ~grant_id;
            resp1_valid <= grant_id;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_xfer) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            last_grant  <= grant_id;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed bench for fp16_mul_arbiter. A behavioural
// multiplier with a latency of 3 cycles looks up products of known FP16 pairs.
module tb_fp16_mul_arbiter;

`ifdef FP_ARB_WATCHDOG_EN
  localparam int TO = 8;
`else
  localparam int TO = 64;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  fp16_mul_arbiter_if bus ();

  fp16_mul_arbiter #(.TIMEOUT(TO), .TW(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: done three cycles after start, product from a table.
  logic        d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
  logic [15:0] pa = 16'h0, pb = 16'h0;
  logic        mul_mute = 1'b0;
  logic        done_force = 1'b0;

  function automatic logic [15:0] fp_lookup(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h4000_4200: fp_lookup = 16'h4600;  // 2 * 3 = 6
      32'h3C00_4500: fp_lookup = 16'h4500;  // 1 * 5 = 5
      32'h4000_4000: fp_lookup = 16'h4400;  // 2 * 2 = 4
      32'h4400_3C00: fp_lookup = 16'h4400;  // 4 * 1 = 4
      32'h3C00_3C00: fp_lookup = 16'h3C00;  // 1 * 1 = 1
      default:       fp_lookup = 16'hFFFF;
    endcase
  endfunction

  always @(posedge clk) begin
    d1 <= bus.mul_start;
    d2 <= d1;
    d3 <= d2;
    if (bus.mul_start) begin
      pa <= bus.mul_a;
      pb <= bus.mul_b;
    end
  end

  assign bus.mul_done = (d3 && !mul_mute) || done_force;
  assign bus.mul_p    = done_force ? 16'hBEEF : fp_lookup(pa, pb);

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    next();
    vectors++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.mul_start,
         bus.busy, bus.grant_id, bus.err} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b required 00000000", {bus.req0_ready, bus.req1_ready,
               bus.resp0_valid, bus.resp1_valid, bus.mul_start, bus.busy, bus.grant_id, bus.err});
    end
    vectors++;
    if ({bus.resp_p, bus.mul_a, bus.mul_b} !== 48'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h %h %h required 0000 0000 0000", bus.resp_p, bus.mul_a, bus.mul_b);
    end
    rst = 1'b1;
    next();
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4200;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b0;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready got %b required 10", {bus.req0_ready, bus.req1_ready});
    end
    next();  // T+1
    bus.req0_valid = 1'b0;
    vectors++;
    if ({bus.mul_start, bus.busy, bus.grant_id, bus.mul_a, bus.mul_b} !== {3'b110, 16'h4000, 16'h4200}) begin
      miscompares++;
      $display("FAIL single_issue got %b%b%b %h %h required 110 4000 4200",
               bus.mul_start, bus.busy, bus.grant_id, bus.mul_a, bus.mul_b);
    end
    for (int k = 2; k <= 4; k++) begin
      next();
      vectors++;
      if ({bus.mul_start, bus.resp0_valid, bus.resp1_valid, bus.busy} !== 4'b0001) begin
        miscompares++;
        $display("FAIL single_wait cyc %0d got %b required 0001", k,
                 {bus.mul_start, bus.resp0_valid, bus.resp1_valid, bus.busy});
      end
    end
    next();  // T+5
    vectors++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_p} !== {2'b10, 16'h4600}) begin
      miscompares++;
      $display("FAIL single_resp got %b%b %h required 10 4600", bus.resp0_valid, bus.resp1_valid, bus.resp_p);
    end
    next();  // T+6
    vectors++;
    if ({bus.resp0_valid, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL single_done got %b required 00", {bus.resp0_valid, bus.busy});
    end
  endtask

  task automatic test_tie();
    rst = 1'b0;
    next();
    rst = 1'b1;
    next();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h3C00; bus.req0_b = 16'h4500;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4000; bus.req1_b = 16'h4000;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie1_ready got %b required 10", {bus.req0_ready, bus.req1_ready});
    end
    next();  // T+1: requester 0 queues a second pair behind requester 1
    bus.req0_a = 16'h4400; bus.req0_b = 16'h3C00;
    vectors++;
    if ({bus.grant_id, bus.mul_a} !== {1'b0, 16'h3C00}) begin
      miscompares++;
      $display("FAIL tie1_grant got %b %h required 0 3c00", bus.grant_id, bus.mul_a);
    end
    repeat (4) next();  // T+5
    vectors++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_p} !== {2'b10, 16'h4500}) begin
      miscompares++;
      $display("FAIL tie1_resp got %b%b %h required 10 4500", bus.resp0_valid, bus.resp1_valid, bus.resp_p);
    end
    next();  // T+6: second tie, requester 1 is owed the turn
    vectors++;
    if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL tie2_ready got %b required 001", {bus.busy, bus.req0_ready, bus.req1_ready});
    end
    next();  // T+7
    bus.req1_valid = 1'b0;
    vectors++;
    if ({bus.grant_id, bus.mul_a, bus.mul_b} !== {1'b1, 16'h4000, 16'h4000}) begin
      miscompares++;
      $display("FAIL tie2_grant got %b %h %h required 1 4000 4000", bus.grant_id, bus.mul_a, bus.mul_b);
    end
    repeat (4) next();  // T+11
    vectors++;
    if ({bus.resp0_valid, bus.resp1_valid, bus.resp_p} !== {2'b01, 16'h4400}) begin
      miscompares++;
      $display("FAIL tie2_resp got %b%b %h required 01 4400", bus.resp0_valid, bus.resp1_valid, bus.resp_p);
    end
    next();  // T+12
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL tie3_ready got %b required 10", {bus.req0_ready, bus.req1_ready});
    end
    next();
    bus.req0_valid = 1'b0;
    repeat (4) next();  // T+17
    vectors++;
    if ({bus.resp0_valid, bus.resp_p} !== {1'b1, 16'h4400}) begin
      miscompares++;
      $display("FAIL tie3_resp got %b %h required 1 4400", bus.resp0_valid, bus.resp_p);
    end
    next();
  endtask

  task automatic test_backpressure();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4200;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b1;
    next();  // T+1
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4000; bus.req1_b = 16'h4000;
    repeat (4) next();  // T+5
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({bus.resp0_valid, bus.resp1_valid, bus.busy, bus.req1_ready, bus.mul_start, bus.resp_p}
          !== {5'b10100, 16'h4600}) begin
        miscompares++;
        $display("FAIL bp_hold cyc %0d got %b%b%b%b%b %h required 10100 4600", i, bus.resp0_valid,
                 bus.resp1_valid, bus.busy, bus.req1_ready, bus.mul_start, bus.resp_p);
      end
      next();
    end
    bus.resp0_ready = 1'b1;
    vectors++;
    if (bus.resp0_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release got %b required 1", bus.resp0_valid);
    end
    next();
    #1;
    vectors++;
    if ({bus.resp0_valid, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_next_ready got %b required 01", {bus.resp0_valid, bus.req1_ready});
    end
    next();
    bus.req1_valid = 1'b0;
    repeat (4) next();
    vectors++;
    if ({bus.resp1_valid, bus.resp_p} !== {1'b1, 16'h4400}) begin
      miscompares++;
      $display("FAIL bp_req1_resp got %b %h required 1 4400", bus.resp1_valid, bus.resp_p);
    end
    next();
  endtask

  task automatic test_spurious_done();
    done_force = 1'b1;  // pulse in IDLE
    next();
    done_force = 1'b0;
    vectors++;
    if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.resp_p} !== {3'b000, 16'h4400}) begin
      miscompares++;
      $display("FAIL spur_idle got %b%b%b %h required 000 4400", bus.busy, bus.resp0_valid,
               bus.resp1_valid, bus.resp_p);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 16'h3C00; bus.req0_b = 16'h3C00;
    bus.resp0_ready = 1'b1;
    next();  // T+1, ISSUE
    bus.req0_valid = 1'b0;
    done_force = 1'b1;
    next();  // T+2
    done_force = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      vectors++;
      if ({bus.busy, bus.resp0_valid, bus.resp1_valid} !== 3'b100) begin
        miscompares++;
        $display("FAIL spur_issue cyc %0d got %b required 100", k, {bus.busy, bus.resp0_valid, bus.resp1_valid});
      end
      next();
    end
    vectors++;  // T+5
    if ({bus.resp0_valid, bus.resp_p} !== {1'b1, 16'h3C00}) begin
      miscompares++;
      $display("FAIL spur_resp got %b %h required 1 3c00", bus.resp0_valid, bus.resp_p);
    end
    next();
  endtask

  task automatic test_reset_mid_wait();
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4200;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    next();  // T+1
    bus.req0_valid = 1'b0;
    next();  // T+2, WAIT
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.grant_id, bus.mul_start, bus.resp0_valid, bus.mul_a, bus.mul_b, bus.resp_p}
        !== {4'b0000, 48'h0}) begin
      miscompares++;
      $display("FAIL rstwait_clear got %b%b%b%b %h %h %h required 0000 0000 0000 0000", bus.busy,
               bus.grant_id, bus.mul_start, bus.resp0_valid, bus.mul_a, bus.mul_b, bus.resp_p);
    end
    next();  // T+3
    rst = 1'b1;
    next();  // T+4, late done arrives
    next();  // T+5
    vectors++;
    if ({bus.busy, bus.resp0_valid, bus.resp1_valid, bus.resp_p} !== {3'b000, 16'h0000}) begin
      miscompares++;
      $display("FAIL rstwait_late_done got %b%b%b %h required 000 0000", bus.busy, bus.resp0_valid,
               bus.resp1_valid, bus.resp_p);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 16'h3C00; bus.req0_b = 16'h4500;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h4000; bus.req1_b = 16'h4000;
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL rstwait_tie got %b required 10", {bus.req0_ready, bus.req1_ready});
    end
    next();
    bus.req0_valid = 1'b0;
    repeat (4) next();
    vectors++;
    if ({bus.resp0_valid, bus.resp_p} !== {1'b1, 16'h4500}) begin
      miscompares++;
      $display("FAIL rstwait_resp0 got %b %h required 1 4500", bus.resp0_valid, bus.resp_p);
    end
    next();
    next();
    bus.req1_valid = 1'b0;
    repeat (4) next();
    vectors++;
    if ({bus.resp1_valid, bus.resp_p} !== {1'b1, 16'h4400}) begin
      miscompares++;
      $display("FAIL rstwait_resp1 got %b %h required 1 4400", bus.resp1_valid, bus.resp_p);
    end
    next();
  endtask

`ifdef FP_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    mul_mute = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4200;
    bus.resp0_ready = 1'b1;
    next();  // T+1
    bus.req0_valid = 1'b0;
    repeat (8) next();  // T+9, last WAIT cycle
    vectors++;
    if ({bus.resp0_valid, bus.err} !== 2'b00) begin
      miscompares++;
      $display("FAIL wd_before got %b required 00", {bus.resp0_valid, bus.err});
    end
    next();  // T+10
    vectors++;
    if ({bus.resp0_valid, bus.err, bus.resp_p} !== {2'b11, 16'h7E00}) begin
      miscompares++;
      $display("FAIL wd_abort got %b%b %h required 11 7e00", bus.resp0_valid, bus.err, bus.resp_p);
    end
    mul_mute = 1'b0;
    repeat (3) next();
    vectors++;
    if ({bus.busy, bus.err} !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_sticky got %b required 01", {bus.busy, bus.err});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL wd_reset got %b required 0", bus.err);
    end
    next();
    rst = 1'b1;
    next();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req0_valid = 1'b0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_spurious_done();
    test_reset_mid_wait();
`ifdef FP_ARB_WATCHDOG_EN
    test_watchdog();
`else
    vectors++;
    if (bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_tied got %b required 0", bus.err);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fp16_mul_arbiter.md
Name: fp16_mul_arbiter

Overview:
- Shares one multi-cycle FP16 (IEEE half) multiplier between two independent requesters.
- Each requester submits an operand pair (a, b) on a valid/ready handshake. The block sequences the multiplier through a start/done handshake and returns the product to the originating requester on a valid/ready response channel.
- Sits between the operand-entry front ends (switch/SAVE capture logic) and the FP16 multiplier core that feeds the seven-segment display path.

Parameters:
- TIMEOUT, 64: cycles allowed in WAIT before watchdog abort (used only with the optional feature).
- TW, 7: width of the watchdog counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_a  in  16  requester 0 operand A (FP16)
- req0_b  in  16  requester 0 operand B (FP16)
- req0_ready  out  1  requester 0 pair accepted this cycle when valid&ready
- req1_valid, req1_a, req1_b, req1_ready: same as requester 0, for requester 1
- resp0_valid  out  1  product available for requester 0
- resp0_ready  in  1  requester 0 consumes product
- resp1_valid  out  1  product available for requester 1
- resp1_ready  in  1  requester 1 consumes product
- resp_p  out  16  product (shared by both response channels)
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_a  out  16  operand A to multiplier, stable from ISSUE through WAIT
- mul_b  out  16  operand B to multiplier, stable from ISSUE through WAIT
- mul_done  in  1  multiplier result valid pulse
- mul_p  in  16  multiplier result
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester currently owning the multiplier
- err  out  1  sticky timeout flag (optional feature only; tied 0 otherwise)

Behaviour:
- Reset (rst=0, async): state=IDLE, last_grant=1, all outputs 0 (resp_p, mul_a, mul_b=16'h0000; grant_id=0; err=0).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration:
  - Only requester 0 valid: pick 0. Only requester 1 valid: pick 1.
  - Both valid: pick !last_grant (round-robin), so after reset requester 0 wins a tie.
  - reqN_ready is combinational, high only for the picked requester and only in IDLE.
  - On valid&ready: capture a/b into mul_a/mul_b, set grant_id, go to ISSUE.
- ISSUE: mul_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - On mul_done=1: resp_p<=mul_p, go to RESP.
  - mul_done is sampled only in WAIT; a pulse in any other state is ignored. The multiplier's minimum latency is therefore 1 cycle after start.
- RESP:
  - resp{grant_id}_valid=1; the other response valid stays 0. resp_p is held.
  - Hold until resp{grant_id}_ready=1; that cycle is the transfer. Then last_grant<=grant_id and go to IDLE.
  - The ready of the non-granted response channel is ignored.
- Latency: accept cycle T, mul_start at T+1, mul_done at T+1+L gives resp_valid at T+2+L. Earliest next accept is the cycle after the response transfer.
- Requests raised while busy wait; valid must stay asserted with operands stable (AXI-style rule). No queueing.
- Reset mid-operation returns to IDLE immediately. An in-flight mul_done arriving after reset is ignored. The multiplier is not aborted (owner of the core resets it on the same rst).
- No FP arithmetic in this block; operands and product pass through bit-exact.

Optional Feature:
- Macro: FP_ARB_WATCHDOG_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT without mul_done: resp_p<=16'h7E00 (qNaN), err<=1 (sticky until reset), go to RESP.
  - A late mul_done is then ignored.
- Disabled: no counter; WAIT waits indefinitely; err tied 0.

Test Plan:
- Bench uses a behavioural multiplier with L=3.
- Single request: req0 a=16'h4000, b=16'h4200 -> mul_start one cycle after accept; resp0_valid 5 cycles after accept with resp_p=16'h4600; resp1_valid stays 0.
- Tie after reset: both valid (req0 3C00*4500, req1 4000*4000) -> req0 served first (resp_p=4500), then req1 (resp_p=4400); a second tie grants req1 first.
- Response backpressure: resp0_ready held 0 for 10 cycles -> resp0_valid and resp_p stable, busy=1, req1_ready=0 throughout; no new mul_start.
- Spurious done: mul_done pulsed in IDLE and in ISSUE -> no state change, no resp_valid.
- Reset mid-WAIT: rst low for 1 cycle during WAIT -> all outputs 0 immediately; the later mul_done is ignored; next request completes normally.
- FP_ARB_WATCHDOG_EN with TIMEOUT=8, multiplier never done -> resp_valid 8 cycles into WAIT, resp_p=16'h7E00, err=1 held after reset deasserts? no: err stays 1 until the next rst.
